// File: rtl/matmul_pkg.sv
// Shared definitions for the result-memory UART dump path: sequencer state
// encoding and 8N1 frame constants.
package matmul_pkg;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } mtu_state_t;

endpackage

// File: rtl/mem_to_uart_if.sv
// Control, memory-read and serial-line bundle of mem_to_uart, plus the
// sequencer state exposed for observation.
interface mem_to_uart_if;
    import matmul_pkg::*;

    // start: one-cycle request, honoured only while the sequencer is idle.
    // mem_rd_en: one-cycle read strobe; mem_rd_data must be valid on the next
    // cycle, and mem_rd_addr holds its value between strobes.
    logic        start;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        tx_data;
    logic        busy;
    logic        done;
    mtu_state_t  fsm_state;

    modport master (
        input  start, mem_rd_data,
        output mem_rd_en, mem_rd_addr, tx_data, busy, done, fsm_state
    );

    modport slave (
        output start, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, tx_data, busy, done, fsm_state
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: load captures a byte and starts a frame, tx_done is
// high during the final cycle of the stop bit.
module uart_tx_serializer
    import matmul_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(FRAME_BITS);

    logic                 active;
    logic [CW-1:0]        clk_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;

    assign bit_end = active && (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_done = bit_end && (bit_idx == IW'(FRAME_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= data;
            tx      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                clk_cnt <= '0;
                if (tx_done) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                    // Indices 1..DATA_BITS carry data LSB first, the rest are stop bits.
                    if (bit_idx < IW'(DATA_BITS)) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end else begin
                        tx <= 1'b1;
                    end
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_to_uart.sv
// Streams ROW*COLUMN bytes from the result memory, address 0 upward, out of a
// UART line, one byte per frame.
module mem_to_uart
    import matmul_pkg::*;
#(
    parameter int ROW          = 2,
    parameter int COLUMN       = 2,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic          clk,
    input  logic          rst,
    mem_to_uart_if.master bus
);

    localparam int TOTAL = ROW * COLUMN;

    mtu_state_t  state;
    logic [31:0] word_cnt;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic        busy;
    logic        done;
    logic        load;
    logic        tx;
    logic        tx_done;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .data   (bus.mem_rd_data),
        .tx     (tx),
        .tx_done(tx_done)
    );

    // NEXT, FETCH and LOAD each take one cycle, giving the three idle-high
    // cycles between a stop bit and the following start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load        <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            load      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state       <= ST_FETCH;
                        word_cnt    <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= '0;
                        busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                    load  <= 1'b1;
                end
                ST_LOAD: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_done) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (word_cnt == 32'(TOTAL - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= ST_FETCH;
                        word_cnt    <= word_cnt + 32'd1;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= word_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en   = mem_rd_en;
    assign bus.mem_rd_addr = mem_rd_addr;
    assign bus.tx_data     = tx;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_mem_to_uart.sv
// Self-checking bench for mem_to_uart: randomized matrix dumps decoded from
// the serial line and compared against an 8N1 reference model.
module tb_mem_to_uart;
    import matmul_pkg::*;

    localparam int CPB       = 4;
    localparam int ROWS      = 2;
    localparam int COLS      = 2;
    localparam int TOTAL     = ROWS * COLS;
    localparam int FRAME_LEN = CPB * FRAME_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_to_uart_if bus();

    mem_to_uart #(
        .ROW         (ROWS),
        .COLUMN      (COLS),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    // result memory with one-cycle read latency
    logic [7:0] mem [TOTAL];
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rd_data <= (bus.mem_rd_addr < 32'(TOTAL)) ? mem[bus.mem_rd_addr[1:0]] : 8'h5A;
    end

    // monitor: samples on the falling edge, away from the active edge
    logic        rec = 1'b0;
    logic        line_q[$];
    logic [31:0] addr_q[$];
    int          done_cnt = 0;
    logic        prev_done = 1'b0;
    logic        busy_after_done = 1'b1;

    always @(negedge clk) begin
        if (rec) line_q.push_back(bus.tx_data);
        if (bus.mem_rd_en === 1'b1) addr_q.push_back(bus.mem_rd_addr);
        if (bus.done === 1'b1) done_cnt++;
        if (prev_done) busy_after_done = bus.busy;
        prev_done = (bus.done === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: expected line level of sample j within a frame of byte b.
    function automatic logic frame_level(input logic [7:0] b, input int j);
        int bit_no;
        bit_no = j / CPB;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= DATA_BITS) return b[bit_no-1];
        return 1'b1;
    endfunction

    task automatic parse_frames(input int base, input string name, input logic [7:0] exp_q[$]);
        int         idx;
        int         lead;
        int         gap;
        int         bad;
        logic [7:0] exp_b;
        logic [7:0] dec;
        logic       s;
        idx  = base;
        lead = 0;
        while (idx < line_q.size() && line_q[idx] == 1'b1) begin
            lead++;
            idx++;
        end
        check({name, "_lead"}, lead, 3);
        for (int f = 0; f < TOTAL; f++) begin
            exp_b = exp_q.pop_front();
            bad   = 0;
            dec   = '0;
            for (int j = 0; j < FRAME_LEN; j++) begin
                s = (idx + j < line_q.size()) ? line_q[idx + j] : 1'bx;
                if (s !== frame_level(exp_b, j)) bad++;
            end
            for (int i = 0; i < DATA_BITS; i++) begin
                if (idx + CPB * (i + 1) + CPB / 2 < line_q.size())
                    dec[i] = line_q[idx + CPB * (i + 1) + CPB / 2];
                else
                    dec[i] = 1'bx;
            end
            check($sformatf("%s_byte%0d", name, f), dec, exp_b);
            check($sformatf("%s_timing%0d", name, f), bad, 0);
            idx += FRAME_LEN;
            gap = 0;
            while (idx < line_q.size() && line_q[idx] == 1'b1) begin
                gap++;
                idx++;
            end
            if (f < TOTAL - 1) check($sformatf("%s_gap%0d", name, f), gap, 3);
        end
        check({name, "_tail_idle"}, idx, line_q.size());
    endtask

    task automatic run_matrix(input int second_start_at, input bit start_in_done, input string name);
        logic [7:0] exp_q[$];
        int         line_base;
        int         addr_base;
        int         done_base;
        int         cyc;
        int         n_addr;
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(mem[i]);
        line_base = line_q.size();
        addr_base = addr_q.size();
        done_base = done_cnt;
        bus.start = 1'b1;
        rec       = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check({name, "_busy_after_start"}, bus.busy, 1'b1);
        cyc = 1;
        while (done_cnt == done_base && cyc < 2000) begin
            bus.start = (cyc == second_start_at) || (start_in_done && bus.done === 1'b1);
            tick(1);
            cyc++;
        end
        bus.start = 1'b0;
        if (cyc >= 2000) check({name, "_done_timeout"}, 1'b0, 1'b1);
        tick(6);
        rec = 1'b0;
        check({name, "_done_pulses"}, done_cnt - done_base, 1);
        check({name, "_busy_after_done"}, busy_after_done, 1'b0);
        check({name, "_busy_end"}, bus.busy, 1'b0);
        check({name, "_tx_end"}, bus.tx_data, 1'b1);
        check({name, "_state_end"}, bus.fsm_state, ST_IDLE);
        n_addr = addr_q.size() - addr_base;
        check({name, "_strobes"}, n_addr, TOTAL);
        for (int i = 0; i < TOTAL && i < n_addr; i++)
            check($sformatf("%s_addr%0d", name, i), addr_q[addr_base + i], i);
        parse_frames(line_base, name, exp_q);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int line_base;
        int addr_base;
        int zeros;
        bus.start = 1'b0;
        mem[0] = 8'h05;
        mem[1] = 8'hA3;
        mem[2] = 8'hFF;
        mem[3] = 8'h00;
        rst = 1'b1;
        tick(3);
        check("rst_tx", bus.tx_data, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rd_en", bus.mem_rd_en, 1'b0);
        check("rst_addr", bus.mem_rd_addr, 32'd0);
        check("rst_state", bus.fsm_state, ST_IDLE);
        rst = 1'b0;

        // idle with no start
        line_base = line_q.size();
        addr_base = addr_q.size();
        rec = 1'b1;
        tick(100);
        rec = 1'b0;
        zeros = 0;
        for (int i = line_base; i < line_q.size(); i++) if (line_q[i] !== 1'b1) zeros++;
        check("idle_line_low", zeros, 0);
        check("idle_strobes", addr_q.size() - addr_base, 0);
        check("idle_busy", bus.busy, 1'b0);

        run_matrix(-1, 1'b0, "full");
        tick(5);
        run_matrix(50, 1'b0, "busy_start");
        tick(5);
        run_matrix(-1, 1'b1, "done_start");
        tick(5);

        // reset during data bit 3 of the second frame
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(63);
        check("midframe_level", bus.tx_data, mem[1][3]);
        rst = 1'b1;
        #1;
        check("abort_tx", bus.tx_data, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_rd_en", bus.mem_rd_en, 1'b0);
        check("abort_state", bus.fsm_state, ST_IDLE);
        tick(2);
        rst = 1'b0;
        addr_base = addr_q.size();
        tick(20);
        check("post_abort_tx", bus.tx_data, 1'b1);
        check("post_abort_strobes", addr_q.size() - addr_base, 0);
        run_matrix(-1, 1'b0, "after_abort");

        // randomized contents, idle spacing and stray start pulses
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < TOTAL; i++) mem[i] = 8'($urandom_range(0, 255));
            tick($urandom_range(1, 20));
            run_matrix(($urandom_range(0, 1) == 1) ? $urandom_range(2, 170) : -1,
                       1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_to_uart.md
MEM_TO_UART -- requirements
Module: mem_to_uart

Interface
REQ-001 Parameter ROW, default 2, number of matrix rows to transmit.
REQ-002 Parameter COLUMN, default 2, number of matrix columns to transmit.
REQ-003 Parameter CLKS_PER_BIT, default 5208, clk cycles per UART bit period (9600 baud at 50 MHz).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to transmit the whole matrix.
REQ-007 mem_rd_en  output  1  read strobe to result memory.
REQ-008 mem_rd_addr  output  32  word address to result memory.
REQ-009 mem_rd_data  input  8  memory read data, valid exactly one clk after mem_rd_en.
REQ-010 tx_data  output  1  serial UART line, idle high.
REQ-011 busy  output  1  high from accepted start until the last stop bit ends.
REQ-012 done  output  1  one-cycle pulse after the final frame completes.

Function
REQ-013 TOTAL = ROW*COLUMN words SHALL be sent, addresses 0..TOTAL-1, ascending, one byte per frame.
REQ-014 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-015 FSM states SHALL be IDLE, FETCH, LOAD, SEND, NEXT, DONE.
REQ-016 IDLE: start=1 -> FETCH; word counter cleared; busy asserted the next cycle.
REQ-017 FETCH: mem_rd_en=1 for exactly one cycle, mem_rd_addr = word counter -> LOAD.
REQ-018 LOAD: mem_rd_data captured into shift register; serializer started -> SEND.
REQ-019 SEND: wait for serializer completion (end of stop bit) -> NEXT.
REQ-020 NEXT: counter = TOTAL-1 -> DONE; else counter+1 -> FETCH.
REQ-021 DONE: done=1 for one cycle, busy deasserted -> IDLE.
REQ-022 Inter-frame gap SHALL be exactly 3 clk cycles of idle-high line (NEXT, FETCH, LOAD).
REQ-023 start while busy=1 SHALL be ignored; no queueing.
REQ-024 start in the same cycle as DONE SHALL be ignored; start is sampled only in IDLE.
REQ-025 mem_rd_addr SHALL hold its last value when mem_rd_en=0; mem_rd_en=0 outside FETCH.
REQ-026 Bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at CLKS_PER_BIT-1.
REQ-027 tx_data SHALL be registered (glitch-free).

Reset
REQ-028 On rst: state IDLE, tx_data=1, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, all counters and shift register 0.
REQ-029 rst mid-frame SHALL abort immediately; line returns high; no further frames until a new start.

Structure
REQ-030 The FSM state encodings and the UART frame constants (DATA_BITS=8, STOP_BITS=1) SHALL live in the shared package matmul_pkg.
REQ-031 The serializer SHALL be the sub-module uart_tx_serializer (ports clk, rst, load, data[7:0], tx, tx_done); mem_to_uart holds the sequencing FSM only.

Verification (CLKS_PER_BIT=4, ROW=COLUMN=2, memory = {0x05,0xA3,0xFF,0x00})
REQ-032 Idle after reset: no start for 100 cycles -> tx_data=1, busy=0, mem_rd_en never asserted.
REQ-033 Full matrix: start pulse -> 4 frames decoded as 0x05,0xA3,0xFF,0x00, each 40 cycles, 3-cycle gaps, done pulses once, busy low the cycle after done.
REQ-034 Bit timing: frame for 0xA3 -> line sequence 0,1,1,0,0,0,1,0,1,1, each held exactly 4 cycles.
REQ-035 Start while busy: second start pulse at cycle 50 -> still exactly 4 frames, one done pulse.
REQ-036 Reset mid-frame: rst asserted during bit 3 of frame 2 -> tx_data=1 same cycle, busy=0; new start sends all 4 frames from address 0.
REQ-037 Address sequence: mem_rd_addr observed at each mem_rd_en strobe = 0,1,2,3, one strobe per frame.
